io_uart_tx: RTL and testbench

//  Transmit-only UART peripheral on the core's IO bus, alongside the LED register.
//  The core writes bytes into a small FIFO; an FSM serialises them 8N1, LSB first, on tx.

---
 rtl/io_uart_tx.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_io_uart_tx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// Transmit-only 8N1 UART on the IO bus: DATA/STAT/DIV registers, byte FIFO, serialiser.
// Optional level interrupt when UART_IRQ_EN is defined (irq = ie && empty && !busy).
module io_uart_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'h1010,
    parameter int unsigned CLK_DIV    = 234,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_r,
    input  logic        io_w,
    input  logic [15:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd4;
    localparam logic [15:0] DIV_ADDR  = BASE_ADDR + 16'd8;
    localparam logic [15:0] DIV_RST   = 16'(CLK_DIV);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_data;
    logic sel_stat;
    logic sel_div;
    logic wr_data;
    logic wr_stat;
    logic wr_div;

    assign sel_data = (io_addr == BASE_ADDR);
    assign sel_stat = (io_addr == STAT_ADDR);
    assign sel_div  = (io_addr == DIV_ADDR);
    assign wr_data  = io_w && sel_data;
    assign wr_stat  = io_w && sel_stat;
    assign wr_div   = io_w && sel_div;

    // Reads have no side effects; the strobe and upper write bits are unused.
    logic unused_ok;
    assign unused_ok = ^{io_r, io_wdata[31:16]};

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push_ok;
    logic push_drop;
    logic pop;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign push_ok   = wr_data && !full;
    assign push_drop = wr_data && full;

    // Pointer and occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; contents are dropped on reset via the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write port (no reset needed, guarded by count).
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= io_wdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Software-visible registers
    // ------------------------------------------------------------------
    logic [7:0]  last_q, last_d;
    logic        ovf_q, ovf_d;
    logic [15:0] div_reg_q, div_reg_d;
    logic        ie_bit;

    // Register writes: DIV of zero is clamped to one, ovf is sticky.
    always_comb begin
        last_d    = last_q;
        ovf_d     = ovf_q;
        div_reg_d = div_reg_q;
        if (push_ok) begin
            last_d = io_wdata[7:0];
        end
        if (wr_stat && io_wdata[3]) begin
            ovf_d = 1'b0;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end
        if (wr_div) begin
            div_reg_d = (io_wdata[15:0] == 16'd0) ? 16'd1 : io_wdata[15:0];
        end
    end

    // Register file flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 8'd0;
            ovf_q     <= 1'b0;
            div_reg_q <= DIV_RST;
        end else begin
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            div_reg_q <= div_reg_d;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        tx_q, tx_d;
    logic        busy;
    logic        bit_end;

    assign busy    = (state_q != ST_IDLE);
    assign bit_end = (cnt_q == div_q - 16'd1);

    // Next state: bits last div_q cycles; a frame chains straight into the next byte.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q + 16'd1;
        div_d     = div_q;
        pop       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    div_d     = div_reg_q;
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d     = 16'd0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = 16'd0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        div_d     = div_reg_q;
                        bit_idx_d = 3'd0;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the current state, registered one cycle later.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // FSM and output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            cnt_q     <= 16'd0;
            div_q     <= DIV_RST;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
        end
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
`ifdef UART_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;

    // Enable bit and registered level interrupt on an idle, drained transmitter.
    always_comb begin
        ie_d = ie_q;
        if (wr_stat) begin
            ie_d = io_wdata[4];
        end
        irq_d = ie_q && empty && !busy;
    end

    // Interrupt flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie_bit = ie_q;
    assign irq    = irq_q;
`else
    assign ie_bit = 1'b0;
    assign irq    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux: undriven when no register is addressed
    // ------------------------------------------------------------------
    logic [31:0] stat_word;

    assign stat_word = {16'd0, 8'(count_q), 3'd0,
                        ie_bit, ovf_q, empty, full, busy};

    assign io_rdata = sel_data ? {24'd0, last_q} :
                      sel_stat ? stat_word :
                      sel_div  ? {16'd0, div_reg_q} :
                      32'bz;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed self-checking bench for io_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
// Irq expectations follow UART_IRQ_EN when the bench is built.
module tb_io_uart_tx;

    localparam logic [15:0] A_DATA = 16'h1010;
    localparam logic [15:0] A_STAT = 16'h1014;
    localparam logic [15:0] A_DIV  = 16'h1018;

`ifdef UART_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        io_r = 1'b0;
    logic        io_w = 1'b0;
    logic [15:0] io_addr = 16'h0000;
    logic [31:0] io_wdata = 32'h0;
    wire  [31:0] io_rdata;
    wire         tx;
    wire         irq;

    int checks = 0;
    int errors = 0;

    io_uart_tx #(
        .BASE_ADDR (16'h1010),
        .CLK_DIV   (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_r    (io_r),
        .io_w    (io_w),
        .io_addr (io_addr),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    // Expected line level at sample i of an 8N1 frame with div cycles/bit.
    function automatic logic frame_bit(input logic [7:0] b,
                                       input int div, input int i);
        int pos;
        pos = i / div;
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic io_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr  = a;
        io_wdata = d;
        io_w     = 1'b1;
        @(posedge clk);
        #1;
        io_w = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [31:0] d);
        io_addr = a;
        io_r    = 1'b1;
        #1;
        d    = io_rdata;
        io_r = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL reset_stat: got %h want 00000004", rd);
        end
        io_read(A_DIV, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL reset_div: got %h want 00000004", rd);
        end
        io_read(A_DATA, rd);
        checks++;
        if (rd !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", rd);
        end
        io_read(16'h1000, rd);
        checks++;
        if (rd !== 32'hzzzz_zzzz && rd !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h want zzzzzzzz", rd);
        end
    endtask

    task automatic test_single_frame;
        logic [31:0] rd;
        int bad;
        io_write(A_DATA, 32'h0000_00A5);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL lat_w0: got %b want 1", tx);
        end
        step();
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL lat_w1: got %b want 1", tx);
        end
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0005) begin
            errors++;
            $display("FAIL busy_stat: got %h want 00000005", rd);
        end
        step();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (tx !== frame_bit(8'hA5, 4, i)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL frame_a5[%0d]: got %b want %b",
                             i, tx, frame_bit(8'hA5, 4, i));
            end
            step();
        end
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL end_stat: got %h want 00000004", rd);
        end
        io_read(A_DATA, rd);
        checks++;
        if (rd !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL data_read: got %h want 000000a5", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic [7:0] bytes [6];
        int bad;
        bytes[0] = 8'h01;
        bytes[1] = 8'h82;
        bytes[2] = 8'h43;
        bytes[3] = 8'hC4;
        bytes[4] = 8'h25;
        bytes[5] = 8'hEE;
        for (int k = 0; k < 6; k++) begin
            io_write(A_DATA, {24'd0, bytes[k]});
        end
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_040B) begin
            errors++;
            $display("FAIL ovf_stat: got %h want 0000040b", rd);
        end
        bad = 0;
        for (int f = 0; f < 5; f++) begin
            for (int i = (f == 0) ? 3 : 0; i < 40; i++) begin
                checks++;
                if (tx !== frame_bit(bytes[f], 4, i)) begin
                    errors++;
                    bad++;
                    if (bad < 5)
                        $display("FAIL b2b_f%0d[%0d]: got %b want %b",
                                 f, i, tx, frame_bit(bytes[f], 4, i));
                end
                step();
            end
        end
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_tx: got %b want 1", tx);
        end
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_000C) begin
            errors++;
            $display("FAIL b2b_stat: got %h want 0000000c", rd);
        end
        io_write(A_STAT, 32'h0000_0008);
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL ovf_clear: got %h want 00000004", rd);
        end
    endtask

    task automatic test_divisor;
        logic [31:0] rd;
        int bad;
        io_write(A_DIV, 32'h0000_0000);
        io_read(A_DIV, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            errors++;
            $display("FAIL div_zero: got %h want 00000001", rd);
        end
        io_write(A_DATA, 32'h0000_003C);
        io_write(A_DATA, 32'h0000_0096);
        io_write(A_DIV, 32'hFFFF_0008);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx !== frame_bit(8'h3C, 1, i)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL div1_frame[%0d]: got %b want %b",
                             i, tx, frame_bit(8'h3C, 1, i));
            end
            step();
        end
        for (int i = 0; i < 80; i++) begin
            checks++;
            if (tx !== frame_bit(8'h96, 8, i)) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL div8_frame[%0d]: got %b want %b",
                             i, tx, frame_bit(8'h96, 8, i));
            end
            step();
        end
        io_read(A_DIV, rd);
        checks++;
        if (rd !== 32'h0000_0008) begin
            errors++;
            $display("FAIL div8_read: got %h want 00000008", rd);
        end
        io_write(A_DIV, 32'h0000_0004);
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] rd;
        int lows;
        io_write(A_DATA, 32'h0000_0000);
        io_write(A_DATA, 32'h0000_0011);
        io_write(A_DATA, 32'h0000_0022);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_data_tx: got %b want 0", tx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_tx: got %b want 1", tx);
        end
        rst = 1'b0;
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL rst_stat: got %h want 00000004", rd);
        end
        io_read(A_DIV, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL rst_div: got %h want 00000004", rd);
        end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL rst_flush: got %0d low cycles want 0", lows);
        end
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        int bad;
        io_write(A_STAT, 32'h0000_0010);
        step();
        checks++;
        if (irq !== IRQ_ON) begin
            errors++;
            $display("FAIL irq_idle: got %b want %b", irq, IRQ_ON);
        end
        io_read(A_STAT, rd);
        checks++;
        if (rd !== (IRQ_ON ? 32'h0000_0014 : 32'h0000_0004)) begin
            errors++;
            $display("FAIL ie_stat: got %h want %h", rd,
                     IRQ_ON ? 32'h0000_0014 : 32'h0000_0004);
        end
        io_write(A_DATA, 32'h0000_005A);
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_push: got %b want 0", irq);
        end
        step();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (tx !== frame_bit(8'h5A, 4, i) || irq !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL irq_frame[%0d]: got tx=%b irq=%b want tx=%b irq=0",
                             i, tx, irq, frame_bit(8'h5A, 4, i));
            end
            step();
        end
        checks++;
        if (irq !== IRQ_ON) begin
            errors++;
            $display("FAIL irq_done: got %b want %b", irq, IRQ_ON);
        end
        io_write(A_STAT, 32'h0000_0000);
        step();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b want 0", irq);
        end
        io_read(A_STAT, rd);
        checks++;
        if (rd !== 32'h0000_0004) begin
            errors++;
            $display("FAIL irq_stat: got %h want 00000004", rd);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_divisor();
        test_reset_mid_frame();
        test_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
